// File: rtl/port_output_buffer.sv
// Per-port output buffer: 16-entry byte store written by the packet receiver,
// drained in order as framed packets (src, dest, size, payload, crc) on a valid/ready stream.
module port_output_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              winc,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] waddr_in,
    output logic              wfull,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] dout_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              overflow_o,
    output logic              addr_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CRC  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr_exp;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W:0]   count;
    state_t            state;
    state_t            state_nxt;
    logic [7:0]        idx;
    logic [7:0]        idx_nxt;
    logic [7:0]        size_r;
    logic [7:0]        size_nxt;
    logic              empty;
    logic              wr;
    logic              pop;

    // Status decodes come only from registered count, never from inputs.
    assign empty   = (count == '0);
    assign wfull   = (count == FULL_CNT);
    assign valid_o = !empty;
    assign wr      = winc && !wfull;
    assign pop     = valid_o && ready_i;
    assign dout_o  = mem[rptr];

    always_ff @(posedge clk1) begin
        if (wr) begin
            mem[waddr_in] <= wdata;
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            wptr_exp   <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            addr_err_o <= 1'b0;
        end else begin
            if (wr) begin
                wptr_exp <= waddr_in + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (winc && wfull) begin
                overflow_o <= 1'b1;
            end
            // The write is still honoured at the receiver's address; we only flag it.
            if (wr && (waddr_in != wptr_exp)) begin
                addr_err_o <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 8'd0;
            size_r <= 8'd0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            size_r <= size_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        size_nxt  = size_r;
        sop_o     = 1'b0;
        eop_o     = 1'b0;
        case (state)
            IDLE: begin
                sop_o = valid_o;
                if (pop) begin
                    state_nxt = HDR;
                    idx_nxt   = 8'd1;
                end
            end
            HDR: begin
                if (pop) begin
                    if (idx == 8'd1) begin
                        idx_nxt = 8'd2;
                    end else begin
                        // Size byte: zero-length packets skip straight to the crc.
                        size_nxt  = 8'(dout_o);
                        state_nxt = (dout_o != '0) ? PAY : CRC;
                    end
                end
            end
            PAY: begin
                if (pop) begin
                    size_nxt = size_r - 8'd1;
                    if (size_r == 8'd1) begin
                        state_nxt = CRC;
                    end
                end
            end
            CRC: begin
                eop_o = valid_o;
                if (pop) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_port_output_buffer.sv
// Directed bench for port_output_buffer: framing, full/overflow, address error,
// underrun and asynchronous reset behaviour.
module tb_port_output_buffer;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic [3:0] waddr_in = 4'd0;
    logic       wfull;
    logic       ready_i = 1'b0;
    logic       valid_o;
    logic [7:0] dout_o;
    logic       sop_o;
    logic       eop_o;
    logic       overflow_o;
    logic       addr_err_o;

    int n_chk = 0;
    int n_pass = 0;
    logic [3:0] wp = 4'd0;

    port_output_buffer #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk1      (clk1),
        .rst       (rst),
        .winc      (winc),
        .wdata     (wdata),
        .waddr_in  (waddr_in),
        .wfull     (wfull),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .dout_o    (dout_o),
        .sop_o     (sop_o),
        .eop_o     (eop_o),
        .overflow_o(overflow_o),
        .addr_err_o(addr_err_o)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        winc = 1'b0;
        ready_i = 1'b0;
        wdata = 8'd0;
        waddr_in = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        wp = 4'd0;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        winc = 1'b1;
        wdata = d;
        waddr_in = wp;
        tick();
        winc = 1'b0;
        wp = wp + 4'd1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (wfull !== 1'b0) $display("FAIL reset_wfull got %0b want 0", wfull); else n_pass++;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %0b want 0", valid_o); else n_pass++;
        n_chk++; if (sop_o !== 1'b0) $display("FAIL reset_sop got %0b want 0", sop_o); else n_pass++;
        n_chk++; if (eop_o !== 1'b0) $display("FAIL reset_eop got %0b want 0", eop_o); else n_pass++;
        n_chk++; if (overflow_o !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow_o); else n_pass++;
        n_chk++; if (addr_err_o !== 1'b0) $display("FAIL reset_addr_err got %0b want 0", addr_err_o); else n_pass++;
        n_chk++; if (dut.count !== 5'd0) $display("FAIL reset_count got %0d want 0", dut.count); else n_pass++;
    endtask

    task automatic test_packet();
        logic [7:0] pkt [6];
        pkt = '{8'd1, 8'd6, 8'd2, 8'd171, 8'd172, 8'd27};
        do_reset();
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_byte(pkt[k]);
            n_chk++; if (valid_o !== 1'b1) $display("FAIL pkt_valid[%0d] got %0b want 1", k, valid_o); else n_pass++;
            n_chk++; if (dout_o !== pkt[k]) $display("FAIL pkt_dout[%0d] got %0d want %0d", k, dout_o, pkt[k]); else n_pass++;
            n_chk++; if (sop_o !== (k == 0)) $display("FAIL pkt_sop[%0d] got %0b want %0b", k, sop_o, (k == 0)); else n_pass++;
            n_chk++; if (eop_o !== (k == 5)) $display("FAIL pkt_eop[%0d] got %0b want %0b", k, eop_o, (k == 5)); else n_pass++;
        end
        tick();
        ready_i = 1'b0;
        n_chk++; if (dut.count !== 5'd0) $display("FAIL pkt_count_end got %0d want 0", dut.count); else n_pass++;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL pkt_valid_end got %0b want 0", valid_o); else n_pass++;
        n_chk++; if (dut.state !== 2'd0) $display("FAIL pkt_state_end got %0d want 0", dut.state); else n_pass++;
    endtask

    task automatic test_zero_size();
        logic [7:0] seq [8];
        seq = '{8'd0, 8'd9, 8'd0, 8'd5, 8'd3, 8'd7, 8'd0, 8'd8};
        do_reset();
        ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_byte(seq[k]);
            n_chk++; if (dout_o !== seq[k]) $display("FAIL zs_dout[%0d] got %0d want %0d", k, dout_o, seq[k]); else n_pass++;
            n_chk++; if (sop_o !== (k % 4 == 0)) $display("FAIL zs_sop[%0d] got %0b want %0b", k, sop_o, (k % 4 == 0)); else n_pass++;
            n_chk++; if (eop_o !== (k % 4 == 3)) $display("FAIL zs_eop[%0d] got %0b want %0b", k, eop_o, (k % 4 == 3)); else n_pass++;
        end
        tick();
        ready_i = 1'b0;
        n_chk++; if (dut.state !== 2'd0) $display("FAIL zs_state_end got %0d want 0", dut.state); else n_pass++;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) begin
            wr_byte(8'h10 + 8'(i));
            if (i == 14) begin
                n_chk++; if (wfull !== 1'b0) $display("FAIL fill_wfull_15 got %0b want 0", wfull); else n_pass++;
            end
        end
        n_chk++; if (wfull !== 1'b1) $display("FAIL fill_wfull_16 got %0b want 1", wfull); else n_pass++;
        n_chk++; if (dut.count !== 5'd16) $display("FAIL fill_count got %0d want 16", dut.count); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        fill16();
        winc = 1'b1; wdata = 8'hEE; waddr_in = wp;
        tick();
        winc = 1'b0;
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL full_overflow got %0b want 1", overflow_o); else n_pass++;
        n_chk++; if (dut.count !== 5'd16) $display("FAIL full_count_drop got %0d want 16", dut.count); else n_pass++;
        n_chk++; if (dout_o !== 8'h10) $display("FAIL full_dout_kept got %0h want 10", dout_o); else n_pass++;
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        n_chk++; if (wfull !== 1'b0) $display("FAIL full_wfull_after_pop got %0b want 0", wfull); else n_pass++;
        n_chk++; if (dut.count !== 5'd15) $display("FAIL full_count_pop got %0d want 15", dut.count); else n_pass++;
        n_chk++; if (dout_o !== 8'h11) $display("FAIL full_dout_next got %0h want 11", dout_o); else n_pass++;
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL full_overflow_sticky got %0b want 1", overflow_o); else n_pass++;
    endtask

    task automatic test_full_simul();
        do_reset();
        fill16();
        winc = 1'b1; wdata = 8'hEE; waddr_in = wp; ready_i = 1'b1;
        tick();
        winc = 1'b0; ready_i = 1'b0;
        n_chk++; if (dut.count !== 5'd15) $display("FAIL simul_count got %0d want 15", dut.count); else n_pass++;
        n_chk++; if (overflow_o !== 1'b1) $display("FAIL simul_overflow got %0b want 1", overflow_o); else n_pass++;
        n_chk++; if (wfull !== 1'b0) $display("FAIL simul_wfull got %0b want 0", wfull); else n_pass++;
        n_chk++; if (dut.mem[0] !== 8'h10) $display("FAIL simul_mem0 got %0h want 10", dut.mem[0]); else n_pass++;
        n_chk++; if (dout_o !== 8'h11) $display("FAIL simul_dout got %0h want 11", dout_o); else n_pass++;
    endtask

    task automatic test_addr_err();
        do_reset();
        winc = 1'b1; wdata = 8'hA5; waddr_in = 4'd3;
        tick();
        winc = 1'b0;
        n_chk++; if (addr_err_o !== 1'b1) $display("FAIL aerr_flag got %0b want 1", addr_err_o); else n_pass++;
        n_chk++; if (dut.mem[3] !== 8'hA5) $display("FAIL aerr_mem3 got %0h want a5", dut.mem[3]); else n_pass++;
        n_chk++; if (dut.count !== 5'd1) $display("FAIL aerr_count got %0d want 1", dut.count); else n_pass++;
        winc = 1'b1; wdata = 8'h5A; waddr_in = 4'd4;
        tick();
        winc = 1'b0;
        n_chk++; if (addr_err_o !== 1'b1) $display("FAIL aerr_sticky got %0b want 1", addr_err_o); else n_pass++;
        n_chk++; if (dut.mem[4] !== 8'h5A) $display("FAIL aerr_mem4 got %0h want 5a", dut.mem[4]); else n_pass++;
        n_chk++; if (dut.count !== 5'd2) $display("FAIL aerr_count2 got %0d want 2", dut.count); else n_pass++;
    endtask

    task automatic test_underrun();
        logic [7:0] hdr [3];
        logic [7:0] tail [5];
        hdr = '{8'd1, 8'd6, 8'd4};
        tail = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd99};
        do_reset();
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_byte(hdr[k]);
            n_chk++; if (dout_o !== hdr[k]) $display("FAIL ur_hdr[%0d] got %0d want %0d", k, dout_o, hdr[k]); else n_pass++;
        end
        tick();
        for (int c = 0; c < 5; c++) begin
            n_chk++; if (valid_o !== 1'b0) $display("FAIL ur_stall_valid[%0d] got %0b want 0", c, valid_o); else n_pass++;
            n_chk++; if (dut.state !== 2'd2) $display("FAIL ur_stall_state[%0d] got %0d want 2", c, dut.state); else n_pass++;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            wr_byte(tail[k]);
            n_chk++; if (dout_o !== tail[k]) $display("FAIL ur_tail[%0d] got %0d want %0d", k, dout_o, tail[k]); else n_pass++;
            n_chk++; if (eop_o !== (k == 4)) $display("FAIL ur_eop[%0d] got %0b want %0b", k, eop_o, (k == 4)); else n_pass++;
        end
        tick();
        n_chk++; if (dut.state !== 2'd0) $display("FAIL ur_state_end got %0d want 0", dut.state); else n_pass++;
        ready_i = 1'b0;
        wr_byte(8'd1);
        wr_byte(8'd6);
        n_chk++; if (dut.count !== 5'd2) $display("FAIL ur_count_pre_rst got %0d want 2", dut.count); else n_pass++;
        #3 rst = 1'b1;
        #1;
        n_chk++; if (valid_o !== 1'b0) $display("FAIL ur_rst_valid got %0b want 0", valid_o); else n_pass++;
        n_chk++; if (dut.count !== 5'd0) $display("FAIL ur_rst_count got %0d want 0", dut.count); else n_pass++;
        n_chk++; if (sop_o !== 1'b0) $display("FAIL ur_rst_sop got %0b want 0", sop_o); else n_pass++;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_zero_size();
        test_full();
        test_full_simul();
        test_addr_err();
        test_underrun();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/port_output_buffer.md
# port_output_buffer

Per-destination output stage directly downstream of the packet receiver: one instance per output port, written by the receiver through its `winc`/`wdata`/`waddr_in` port signals, returning `wfull`. It stores up to 16 bytes and drains them in order as framed packets. The packet format is src_id, dest_id, size, `size` payload bytes, crc. The output uses a valid/ready byte stream with start/end-of-packet markers toward the port driver.

## Interface
- DATA_W, 8, byte width
- ADDR_W, 4, address width; must match the receiver's `waddr_in_port_*` width
- DEPTH, 16, number of entries, 2**ADDR_W
- clk1  input  1  single clock, all logic rising-edge
- rst  input  1  asynchronous, active-high reset
- winc  input  1  write strobe from receiver (`winc_port_n`)
- wdata  input  DATA_W  write byte (`wdata_port_n`)
- waddr_in  input  ADDR_W  write address supplied by receiver (`waddr_in_port_n`)
- wfull  output  1  buffer full, to receiver (`wfull_port_n`)
- ready_i  input  1  downstream accepts byte this cycle
- valid_o  output  1  `dout_o` holds a valid byte
- dout_o  output  DATA_W  output byte
- sop_o  output  1  current byte is src_id (first of packet)
- eop_o  output  1  current byte is crc (last of packet)
- overflow_o  output  1  sticky: write attempted while full
- addr_err_o  output  1  sticky: `waddr_in` differed from the expected write pointer

## Operation
- Storage: DEPTH x DATA_W register array, not reset. Registers `wptr_exp`, `rptr` (ADDR_W, wrap modulo DEPTH), `count` (ADDR_W+1, range 0..DEPTH).
- Write: if `winc && !wfull`, write `mem[waddr_in] <= wdata` and `wptr_exp <= waddr_in+1`. If `waddr_in != wptr_exp`, the write still happens and `addr_err_o` is set.
- If `winc && wfull`, nothing is written, pointers and count are unchanged, and `overflow_o` is set.
- Pop: a pop occurs when `valid_o && ready_i`. On a pop, `rptr <= rptr+1`.
- Count: write-only gives +1, pop-only gives -1, and simultaneous write and pop leaves it unchanged. A write while full is not a write.
- `wfull = (count == DEPTH)`. `empty = (count == 0)`. Both are decoded from registers, with no combinational path from the inputs.
- Read data is show-ahead: `dout_o = mem[rptr]`.
- Framing FSM, with byte counter `idx` (8 bit) and `size_r` (8 bit):
  - IDLE: `valid_o = !empty`, `sop_o = valid_o`. On pop, go to HDR with `idx = 1`.
  - HDR: `valid_o = !empty`. On the pop at `idx == 1` (dest_id), `idx = 2`. On the pop at `idx == 2` (size), capture `size_r = dout_o`. Then go to PAY if `dout_o != 0`, else go to CRC.
  - PAY: `valid_o = !empty`. Each pop decrements `size_r`. The pop with `size_r == 1` moves to CRC.
  - CRC: `valid_o = !empty`, `eop_o = valid_o`. On pop, return to IDLE.
- `sop_o` and `eop_o` are only asserted together with `valid_o`.
- Underrun mid-packet (empty while not in IDLE): `valid_o` deasserts and the FSM holds state until more bytes arrive. There is no timeout.
- No CRC checking or trust filtering; the receiver has already done that. Bytes are forwarded verbatim.

## Timing
- Reset values: `wfull = 0`, `valid_o = 0`, `dout_o = mem[0]` (X until written, don't care), `sop_o = 0`, `eop_o = 0`, `overflow_o = 0`, `addr_err_o = 0`. Internal state: FSM = IDLE, `count = 0`, `rptr = 0`, `wptr_exp = 0`.
- Reset mid-packet discards all buffered bytes and the FSM returns to IDLE immediately (asynchronous).
- Write-to-read latency: a byte written at edge N is presented on `valid_o`/`dout_o` after edge N when the buffer was empty. Minimum latency is 1 cycle.
- `wfull` rises the cycle after the 16th outstanding write. It falls the cycle after the first subsequent pop.
- Full buffer with simultaneous `winc` and pop: the write is dropped (`wfull` was 1), `overflow_o` is set, and `count` becomes 15.
- Throughput: one byte per cycle in each direction while `ready_i` is held high and the buffer is non-empty.
- Pointer wrap 15 -> 0 is seamless. Sticky flags clear only on `rst`.

## Test plan
- Packet 1, 6, 2, 171, 172, 27 written at `waddr_in` 0..5 with `ready_i = 1`: `dout_o` sequence is 1, 6, 2, 171, 172, 27 on consecutive cycles. `sop_o` is set only with 1, `eop_o` only with 27. `count` ends at 0.
- size = 0 packet 0, 9, 0, 5: `eop_o` is on byte 5 (4th byte) and the FSM returns to IDLE. A following packet gets `sop_o` on its first byte.
- `ready_i = 0`, 16 writes: `wfull = 1` after the 16th edge. A 17th `winc` is dropped and `overflow_o = 1`. One pop then gives `wfull = 0`.
- Full buffer, `winc` and pop in the same cycle: the write is dropped, `count = 15`, and `overflow_o` is set.
- Write at `waddr_in = 3` when 0 is expected: `addr_err_o = 1` and sticky, and data lands at `mem[3]`.
- Header bytes 1, 6, 4 then stall for 5 cycles with the buffer empty: `valid_o = 0` and the FSM stays in PAY. When the remaining 4 payload bytes + crc arrive, `eop_o` appears on the crc. Asserting `rst` mid-stream clears `valid_o` and `count` immediately.
